axis_output_unpacker: RTL and testbench

- Output-side counterpart of the input pipe: drains wide result beats from the conv/accumulator side and serializes them onto a narrow AXI-Stream master toward the DMA.
- Accepts one S_WORDS-word beat, emits it as consecutive M_WORDS-word beats, word 0 first.
- Per-word tkeep and tlast are propagated; a partial last sub-beat is trimmed.
- Single registered stage: no combinational path from any s_axis input to any m_axis output.

---
 rtl/axis_output_unpacker.sv | 136 +++++++++++++
 tb/tb_axis_output_unpacker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_output_unpacker.sv
// axis_output_unpacker: latches one wide result beat and replays it
// as narrow AXI-Stream beats, word 0 first, trimming the tail.
module axis_output_unpacker #(
  parameter int WORD_WIDTH = 8,
  parameter int S_WORDS    = 8,
  parameter int M_WORDS    = 2,
  parameter int BITS_SUB   = $clog2(S_WORDS / M_WORDS) + 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [WORD_WIDTH*S_WORDS-1:0] s_axis_tdata,
  input  logic [S_WORDS-1:0]            s_axis_tkeep,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [WORD_WIDTH*M_WORDS-1:0] m_axis_tdata,
  output logic [M_WORDS-1:0]            m_axis_tkeep,
  output logic                          m_axis_tlast
);

  localparam int NSUB = S_WORDS / M_WORDS;
  localparam int SELW = (NSUB > 1) ? $clog2(NSUB) : 1;
  localparam int CNTW = $clog2(S_WORDS + 1);
  localparam int MW   = WORD_WIDTH * M_WORDS;

  if ((S_WORDS % M_WORDS) != 0) begin : g_bad_ratio
    $error("S_WORDS must be a multiple of M_WORDS");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic                         rdy_q;
  logic [NSUB-1:0][MW-1:0]      data_q, data_d;
  logic [NSUB-1:0][M_WORDS-1:0] keep_q, keep_d;
  logic                         last_q, last_d;
  logic [BITS_SUB-1:0]          cnt_q, cnt_d;
  logic [BITS_SUB-1:0]          nsub_q, nsub_d;

  logic [CNTW-1:0]     n_words;
  logic [BITS_SUB-1:0] n_sub_in;
  logic [SELW-1:0]     sel;
  logic                last_sub;
  logic                send;
  logic                s_hs;
  logic                m_hs;

  // Count kept words of the incoming beat.
  always_comb begin
    n_words = '0;
    for (int i = 0; i < S_WORDS; i++) begin
      n_words = n_words + CNTW'(s_axis_tkeep[i]);
    end
  end

  // Sub-beats needed; a bare tlast still costs one beat.
  always_comb begin
    n_sub_in = BITS_SUB'((int'(n_words) + M_WORDS - 1) / M_WORDS);
    if (n_sub_in == '0 && s_axis_tlast) begin
      n_sub_in = BITS_SUB'(1);
    end
  end

  assign sel      = cnt_q[SELW-1:0];
  assign send     = (state_q == SEND);
  assign last_sub = (cnt_q == nsub_q - BITS_SUB'(1));

  assign s_axis_tready = rdy_q &
    (!send | (last_sub & m_axis_tready));

  assign s_hs = s_axis_tvalid & s_axis_tready;
  assign m_hs = send & m_axis_tready;

  assign m_axis_tvalid = send;
  assign m_axis_tdata  = send ? data_q[sel] : '0;
  assign m_axis_tkeep  = send ? keep_q[sel] : '0;
  assign m_axis_tlast  = send & last_q & last_sub;

  // Next state: step through sub-beats, reload on accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nsub_d  = nsub_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    unique case (state_q)
      EMPTY: ;
      SEND: begin
        if (m_hs) begin
          if (!last_sub) begin
            cnt_d = cnt_q + BITS_SUB'(1);
          end else begin
            state_d = EMPTY;
          end
        end
      end
    endcase
    if (s_hs) begin
      data_d  = s_axis_tdata;
      keep_d  = s_axis_tkeep;
      last_d  = s_axis_tlast;
      nsub_d  = n_sub_in;
      cnt_d   = '0;
      state_d = (n_sub_in != '0) ? SEND : EMPTY;
    end
  end

  // State and buffer registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      nsub_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      nsub_q  <= nsub_d;
    end
  end

endmodule

// File: tb/tb_axis_output_unpacker.sv
// tb_axis_output_unpacker: random and directed stimulus checked
// against a queue-based reference of expected output beats.
module tb_axis_output_unpacker;

  localparam int W  = 8;
  localparam int S  = 8;
  localparam int M  = 2;
  localparam int MW = W * M;

  logic          aclk;
  logic          aresetn;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W*S-1:0] s_axis_tdata;
  logic [S-1:0]  s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [MW-1:0] m_axis_tdata;
  logic [M-1:0]  m_axis_tkeep;
  logic          m_axis_tlast;

  axis_output_unpacker #(
    .WORD_WIDTH(W),
    .S_WORDS(S),
    .M_WORDS(M)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast)
  );

  typedef struct {
    logic [MW-1:0] d;
    logic [M-1:0]  k;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    in_cyc[$];
  int    out_cyc[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  int    nlast  = 0;
  int    mode   = 0;

  logic          stall_q = 1'b0;
  logic [MW-1:0] pd;
  logic [M-1:0]  pk;
  logic          pl;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Downstream ready: 0 = low, 1 = high, 2 = random.
  always @(posedge aclk) begin
    #1;
    case (mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: scoreboard, stall stability, cycle log.
  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_v", m_axis_tvalid, 1);
        chk("stall_d", m_axis_tdata, pd);
        chk("stall_k", m_axis_tkeep, pk);
        chk("stall_l", m_axis_tlast, pl);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexp_beat", exp_q.size(), 1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_d", m_axis_tdata, e.d);
          chk("out_k", m_axis_tkeep, e.k);
          chk("out_l", m_axis_tlast, e.l);
        end
        out_cyc.push_back(cyc);
        if (m_axis_tlast) nlast++;
      end
      if (s_axis_tvalid && s_axis_tready) in_cyc.push_back(cyc);
      stall_q = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pk = m_axis_tkeep;
      pl = m_axis_tlast;
    end
  end

  // Reference: split a wide beat into the expected narrow beats.
  task automatic model(logic [W*S-1:0] d, logic [S-1:0] k, logic l);
    int nw;
    int ns;
    beat_t b;
    nw = $countones(k);
    ns = (nw + M - 1) / M;
    if (ns == 0 && l) ns = 1;
    for (int i = 0; i < ns; i++) begin
      b.d = d[i*MW +: MW];
      b.k = k[i*M +: M];
      b.l = l && (i == ns - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send(logic [W*S-1:0] d, logic [S-1:0] k, logic l);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    model(d, k, l);
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      n++;
      if (n > 300) begin
        chk("s_ready_to", s_axis_tready, 1);
        break;
      end
    end
    @(posedge aclk);
    #2;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
      @(posedge aclk);
      #2;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic logic [S-1:0] ckeep(int nk);
    logic [15:0] t;
    t = (16'(1) << nk) - 16'(1);
    return t[S-1:0];
  endfunction

  function automatic logic [W*S-1:0] rdata();
    return {$urandom, $urandom};
  endfunction

  logic [W*S-1:0] seq = 64'h0807060504030201;
  int nl0;
  int n0;

  initial begin
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    #1 aresetn = 1'b0;
    #2;
    chk("rst_srdy", s_axis_tready, 0);
    chk("rst_v", m_axis_tvalid, 0);
    chk("rst_d", m_axis_tdata, 0);
    chk("rst_k", m_axis_tkeep, 0);
    chk("rst_l", m_axis_tlast, 0);
    @(posedge aclk);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    chk("rdy_pre", s_axis_tready, 0);
    mode = 1;
    @(posedge aclk);
    #2;
    chk("rdy_post", s_axis_tready, 1);

    // Full beat, one-cycle latency.
    send(seq, 8'hFF, 1'b0);
    chk("lat_v", m_axis_tvalid, 1);
    chk("lat_d", m_axis_tdata, 16'h0201);
    drain();

    // Partial last beat.
    nl0 = nlast;
    send(seq, 8'h1F, 1'b1);
    drain();
    chk("part_last", nlast - nl0, 1);

    // Zero keep, no tlast: dropped.
    n0 = out_cyc.size();
    send(seq, 8'h00, 1'b0);
    repeat (3) @(posedge aclk);
    #2;
    chk("zk_rdy", s_axis_tready, 1);
    chk("zk_v", m_axis_tvalid, 0);
    chk("zk_nout", out_cyc.size() - n0, 0);

    // Zero keep with tlast: one empty tlast beat.
    nl0 = nlast;
    n0 = out_cyc.size();
    send(seq, 8'h00, 1'b1);
    drain();
    chk("zkl_nout", out_cyc.size() - n0, 1);
    chk("zkl_last", nlast - nl0, 1);

    // Back-to-back full beats.
    in_cyc.delete();
    out_cyc.delete();
    send(rdata(), 8'hFF, 1'b0);
    send(rdata(), 8'hFF, 1'b1);
    drain();
    chk("b2b_nin", in_cyc.size(), 2);
    chk("b2b_nout", out_cyc.size(), 8);
    if (in_cyc.size() == 2 && out_cyc.size() == 8) begin
      chk("b2b_gap", in_cyc[1] - in_cyc[0], 4);
      for (int i = 0; i < 8; i++) begin
        chk("b2b_ocyc", out_cyc[i] - in_cyc[0], i + 1);
      end
    end
    chk("b2b_rdy", s_axis_tready, 1);

    // Backpressure: 3 packets of 3 beats.
    mode = 2;
    nl0 = nlast;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 3; b++) begin
        send(rdata(), (b == 2) ? 8'h07 : 8'hFF, b == 2);
      end
    end
    drain();
    chk("bp_lasts", nlast - nl0, 3);

    // Random contiguous keeps and tlasts.
    for (int i = 0; i < 40; i++) begin
      send(rdata(), ckeep($urandom_range(0, 8)),
           1'($urandom_range(0, 1)));
    end
    drain();

    // Reset mid-packet.
    mode = 1;
    @(posedge aclk);
    #2;
    n0 = out_cyc.size();
    send(rdata(), 8'hFF, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (out_cyc.size() - n0 >= 2) break;
      @(negedge aclk);
    end
    @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    chk("mrst_v", m_axis_tvalid, 0);
    chk("mrst_d", m_axis_tdata, 0);
    chk("mrst_k", m_axis_tkeep, 0);
    chk("mrst_l", m_axis_tlast, 0);
    chk("mrst_srdy", s_axis_tready, 0);
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk);
    #2;
    chk("mrst_idle", m_axis_tvalid, 0);
    send(seq, 8'hFF, 1'b1);
    chk("mrst_w0", m_axis_tdata, 16'h0201);
    drain();

    chk("end_q", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
